// File: rtl/spi_mpu_bridge_if.sv
`default_nettype none
// ============================================================================
// spi_mpu_bridge_if : ChronoCube MPU-side bus (active-low strobes, address, data)
// Revision 1.0
// ============================================================================
interface spi_mpu_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  _mpu_en;
  logic                  _mpu_rd;
  logic                  _mpu_wr;
  logic [1:0]            _mpu_be;
  logic [ADDR_WIDTH-1:0] mpu_addr;
  logic [DATA_WIDTH-1:0] mpu_data_out;
  logic [DATA_WIDTH-1:0] mpu_data_in;
  logic                  busy;

  modport master (
    output _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr, mpu_data_out, busy,
    input  mpu_data_in
  );

  modport slave (
    input  _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr, mpu_data_out, busy,
    output mpu_data_in
  );
endinterface
`default_nettype wire

// File: rtl/spi_mpu_bridge.sv
`default_nettype none
// ============================================================================
// spi_mpu_bridge : oversampled SPI-slave (mode 0) to MPU bus initiator, bursts
// with address auto-increment and read prefetch.   Revision 1.0
// ============================================================================
module spi_mpu_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        _spi_ss,
  input  wire logic        spi_sclk,
  input  wire logic        spi_mosi,
  output logic             spi_miso,
  spi_mpu_bridge_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE1 = 3'd2,
    S_STROBE2 = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  logic [1:0]            r_ss_sync;
  logic [1:0]            r_sclk_sync;
  logic [1:0]            r_mosi_sync;
  logic                  r_sclk_d;
  logic                  r_in_frame;

  logic                  w_ss;
  logic                  w_mosi;
  logic                  w_rise_ok;
  logic                  w_fall_ok;
  logic                  w_byte_done;
  logic [7:0]            w_rx_byte;

  logic [2:0]            r_bit_cnt;
  logic [1:0]            r_byte_cnt;
  logic                  r_half;
  logic                  r_load_pend;
  logic                  r_cmd_wr;
  logic [1:0]            r_be;
  logic [6:0]            r_rx_sr;
  logic [7:0]            r_addr_hi;
  logic [7:0]            r_wr_hi;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [15:0]           r_miso_sr;

  logic                  w_req;
  logic                  w_req_rd;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [15:0]           w_req_data;

  state_t                r_state;
  state_t                w_next;
  logic                  r_cyc_rd;
  logic [ADDR_WIDTH-1:0] r_mpu_addr;
  logic [DATA_WIDTH-1:0] r_mpu_dout;
  logic [DATA_WIDTH-1:0] r_rd_buf;
  logic                  w_en_n;
  logic                  w_rd_n;
  logic                  w_wr_n;
  logic                  w_busy;

  // A frame is live from the cycle after synchronized SS falls; keeping the
  // previous value lets a rising edge coincident with SS rise still complete.
  assign w_ss        = r_ss_sync[1];
  assign w_mosi      = r_mosi_sync[1];
  assign w_rise_ok   = r_sclk_sync[1] & ~r_sclk_d & r_in_frame;
  assign w_fall_ok   = ~r_sclk_sync[1] & r_sclk_d & r_in_frame & ~w_ss;
  assign w_rx_byte   = {r_rx_sr, w_mosi};
  assign w_byte_done = w_rise_ok & (r_bit_cnt == 3'd7);
  assign w_addr_next = r_addr + ADDR_WIDTH'(1);

  always_comb begin
    w_req      = 1'b0;
    w_req_rd   = 1'b0;
    w_req_addr = r_addr;
    w_req_data = {r_wr_hi, w_rx_byte};
    if (w_byte_done && (r_byte_cnt == 2'd2) && !r_cmd_wr) begin
      w_req      = 1'b1;
      w_req_rd   = 1'b1;
      w_req_addr = ADDR_WIDTH'({r_addr_hi, w_rx_byte});
    end else if (w_byte_done && (r_byte_cnt == 2'd3) && r_cmd_wr && r_half) begin
      w_req      = 1'b1;
    end else if (w_fall_ok && r_load_pend) begin
      w_req      = 1'b1;
      w_req_rd   = 1'b1;
      w_req_addr = w_addr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ss_sync   <= 2'b11;
      r_sclk_sync <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_in_frame  <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 2'd0;
      r_half      <= 1'b0;
      r_load_pend <= 1'b0;
      r_cmd_wr    <= 1'b0;
      r_be        <= 2'b00;
      r_rx_sr     <= 7'd0;
      r_addr_hi   <= 8'd0;
      r_wr_hi     <= 8'd0;
      r_addr      <= '0;
      r_miso_sr   <= 16'd0;
    end else begin
      r_ss_sync   <= {r_ss_sync[0], _spi_ss};
      r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_sclk_d    <= r_sclk_sync[1];
      r_in_frame  <= ~w_ss;

      if (w_rise_ok) begin
        r_rx_sr   <= w_rx_byte[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          case (r_byte_cnt)
            2'd0: begin
              r_cmd_wr   <= w_rx_byte[7];
              r_be       <= w_rx_byte[1:0];
              r_byte_cnt <= 2'd1;
            end
            2'd1: begin
              r_addr_hi  <= w_rx_byte;
              r_byte_cnt <= 2'd2;
            end
            2'd2: begin
              r_addr     <= ADDR_WIDTH'({r_addr_hi, w_rx_byte});
              r_half     <= 1'b0;
              r_byte_cnt <= 2'd3;
            end
            default: begin
              // Data phase: writes pair bytes into words; reads load MISO on
              // the falling edge after every even data byte (dummy first).
              r_half <= ~r_half;
              if (r_cmd_wr) begin
                if (!r_half) r_wr_hi <= w_rx_byte;
                else         r_addr  <= w_addr_next;
              end else if (!r_half) begin
                r_load_pend <= 1'b1;
              end
            end
          endcase
        end
      end

      if (w_fall_ok) begin
        if (r_load_pend) begin
          r_miso_sr   <= 16'(r_rd_buf);
          r_load_pend <= 1'b0;
          r_addr      <= w_addr_next;
        end else begin
          r_miso_sr   <= {r_miso_sr[14:0], 1'b0};
        end
      end

      if (w_ss) begin
        r_bit_cnt   <= 3'd0;
        r_byte_cnt  <= 2'd0;
        r_half      <= 1'b0;
        r_load_pend <= 1'b0;
        r_miso_sr   <= 16'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cyc_rd   <= 1'b0;
      r_mpu_addr <= '0;
      r_mpu_dout <= '0;
      r_rd_buf   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_req) begin
        r_cyc_rd   <= w_req_rd;
        r_mpu_addr <= w_req_addr;
        if (!w_req_rd) r_mpu_dout <= DATA_WIDTH'(w_req_data);
      end
      if ((r_state == S_STROBE2) && r_cyc_rd) begin
        r_rd_buf <= bus.mpu_data_in;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_en_n = 1'b1;
    w_rd_n = 1'b1;
    w_wr_n = 1'b1;
    w_busy = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_req) w_next = S_SETUP;
      end
      S_SETUP: begin
        w_en_n = 1'b0;
        w_rd_n = ~r_cyc_rd;
        w_next = S_STROBE1;
      end
      S_STROBE1: begin
        w_en_n = 1'b0;
        w_rd_n = ~r_cyc_rd;
        w_wr_n = r_cyc_rd;
        w_next = S_STROBE2;
      end
      S_STROBE2: begin
        w_en_n = 1'b0;
        w_rd_n = ~r_cyc_rd;
        w_wr_n = r_cyc_rd;
        w_next = S_HOLD;
      end
      S_HOLD: begin
        w_en_n = 1'b0;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign bus._mpu_en      = w_en_n;
  assign bus._mpu_rd      = w_rd_n;
  assign bus._mpu_wr      = w_wr_n;
  assign bus._mpu_be      = (r_state == S_IDLE) ? 2'b11 : r_be;
  assign bus.mpu_addr     = r_mpu_addr;
  assign bus.mpu_data_out = r_mpu_dout;
  assign bus.busy         = w_busy;
  assign spi_miso         = r_miso_sr[15];

endmodule
`default_nettype wire

// File: tb/tb_spi_mpu_bridge.sv
`default_nettype none
// ============================================================================
// tb_spi_mpu_bridge : directed SPI frames with a bus-cycle scoreboard.
// Revision 1.0
// ============================================================================
module tb_spi_mpu_bridge;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic ss    = 1'b1;
  logic sclk  = 1'b0;
  logic mosi  = 1'b0;
  logic miso;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_cycles = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    int          en_lo;
    int          strb_lo;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [7:0] tx_bytes[$];
  logic [7:0] rx_bytes[$];

  spi_mpu_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  spi_mpu_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    ._spi_ss  (ss),
    .spi_sclk (sclk),
    .spi_mosi (mosi),
    .spi_miso (miso),
    .bus      (bus)
  );

  assign bus.mpu_data_in = bus.mpu_addr ^ 16'hA5A5;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input bit wr, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] be, input int en_lo, input int strb_lo);
    cyc_t c;
    c.wr = wr; c.addr = a; c.data = d; c.be = be; c.en_lo = en_lo; c.strb_lo = strb_lo;
    exp_q.push_back(c);
  endtask

  // Mode-0 host: 6 clk per sclk phase; MISO sampled as sclk rises.
  task automatic run_frame(input int nbits, input bit end_with_ss);
    logic [7:0] rb;
    rb = 8'h00;
    rx_bytes.delete();
    @(negedge clk);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx_bytes[i / 8][7 - (i % 8)];
      repeat (6) @(negedge clk);
      sclk = 1'b1;
      rb   = {rb[6:0], miso};
      if ((i % 8) == 7) rx_bytes.push_back(rb);
      repeat (6) @(negedge clk);
      sclk = 1'b0;
      if ((i == nbits - 1) && end_with_ss) ss = 1'b1;
    end
    repeat (6) @(negedge clk);
    ss   = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Bus monitor: one record per _mpu_en low period, scored against exp_q.
  initial begin : monitor
    bit   in_cyc;
    cyc_t cur;
    cyc_t e;
    in_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (bus._mpu_en === 1'b0) begin
        if (!in_cyc) begin
          in_cyc      = 1'b1;
          cur.addr    = bus.mpu_addr;
          cur.data    = bus.mpu_data_out;
          cur.be      = bus._mpu_be;
          cur.wr      = 1'b0;
          cur.en_lo   = 0;
          cur.strb_lo = 0;
          check("busy_in_cycle", 32'(bus.busy), 1);
        end
        cur.en_lo++;
        if (bus._mpu_wr === 1'b0) begin cur.wr = 1'b1; cur.strb_lo++; end
        if (bus._mpu_rd === 1'b0) cur.strb_lo++;
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        n_cycles++;
        check("cycle_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("cyc_kind",    32'(cur.wr),      32'(e.wr));
          check("cyc_addr",    32'(cur.addr),    32'(e.addr));
          check("cyc_be",      32'(cur.be),      32'(e.be));
          check("cyc_en_lo",   cur.en_lo,        e.en_lo);
          check("cyc_strb_lo", cur.strb_lo,      e.strb_lo);
          if (e.wr) check("cyc_wdata", 32'(cur.data), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  cyc_before;
    bit  found;
    int  k;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_en",   32'(bus._mpu_en), 1);
    check("rst_rd",   32'(bus._mpu_rd), 1);
    check("rst_wr",   32'(bus._mpu_wr), 1);
    check("rst_be",   32'(bus._mpu_be), 2'b11);
    check("rst_addr", 32'(bus.mpu_addr), 0);
    check("rst_dout", 32'(bus.mpu_data_out), 0);
    check("rst_miso", 32'(miso), 0);
    check("rst_busy", 32'(bus.busy), 0);

    // Single write
    tx_bytes = '{8'h80, 8'h01, 8'h23, 8'hBE, 8'hEF};
    push_exp(1'b1, 16'h0123, 16'hBEEF, 2'b00, 4, 2);
    run_frame(40, 1'b0);
    check("single_done", exp_q.size(), 0);

    // Burst write across the address wrap
    tx_bytes = '{8'h80, 8'hFF, 8'hFF, 8'h11, 8'h11, 8'h22, 8'h22};
    push_exp(1'b1, 16'hFFFF, 16'h1111, 2'b00, 4, 2);
    push_exp(1'b1, 16'h0000, 16'h2222, 2'b00, 4, 2);
    run_frame(56, 1'b0);
    check("burst_done", exp_q.size(), 0);

    // Burst read: two words plus one prefetch; frame ends with SS on last fall
    tx_bytes = '{8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_exp(1'b0, 16'h0040, 16'h0000, 2'b00, 4, 3);
    push_exp(1'b0, 16'h0041, 16'h0000, 2'b00, 4, 3);
    push_exp(1'b0, 16'h0042, 16'h0000, 2'b00, 4, 3);
    run_frame(64, 1'b1);
    check("read_done", exp_q.size(), 0);
    check("read_nbytes", rx_bytes.size(), 8);
    if (rx_bytes.size() == 8) begin
      check("read_word0", {16'h0, rx_bytes[4], rx_bytes[5]}, 32'hA5E5);
      check("read_word1", {16'h0, rx_bytes[6], rx_bytes[7]}, 32'hA5E4);
    end

    // Byte enables
    tx_bytes = '{8'h82, 8'h00, 8'h10, 8'h00, 8'hFF};
    push_exp(1'b1, 16'h0010, 16'h00FF, 2'b10, 4, 2);
    run_frame(40, 1'b0);
    check("be_done", exp_q.size(), 0);
    check("be_idle", 32'(bus._mpu_be), 2'b11);

    // Abort after 9 bits of a data word, then a clean frame
    cyc_before = n_cycles;
    tx_bytes = '{8'h80, 8'h02, 8'h00, 8'hAB, 8'hCD};
    run_frame(33, 1'b0);
    check("abort_no_cycle", n_cycles, cyc_before);
    tx_bytes = '{8'h81, 8'h03, 8'h00, 8'h12, 8'h34};
    push_exp(1'b1, 16'h0300, 16'h1234, 2'b01, 4, 2);
    run_frame(40, 1'b0);
    check("post_abort_done", exp_q.size(), 0);

    // Reset during STROBE1 of a write: cycle seen truncated to SETUP+STROBE1
    tx_bytes = '{8'h80, 8'h05, 8'h00, 8'hCA, 8'hFE};
    push_exp(1'b1, 16'h0500, 16'hCAFE, 2'b00, 2, 1);
    fork
      run_frame(40, 1'b0);
      begin
        found = 1'b0;
        k     = 0;
        while (!found && (k < 3000)) begin
          @(negedge clk);
          if (bus._mpu_wr === 1'b0) found = 1'b1;
          k++;
        end
        check("rst_mid_strobe_seen", 32'(found), 1);
        if (found) begin
          reset = 1'b1;
          @(posedge clk);
          #1;
          check("rstm_wr",   32'(bus._mpu_wr), 1);
          check("rstm_en",   32'(bus._mpu_en), 1);
          check("rstm_rd",   32'(bus._mpu_rd), 1);
          check("rstm_busy", 32'(bus.busy), 0);
          check("rstm_be",   32'(bus._mpu_be), 2'b11);
          check("rstm_addr", 32'(bus.mpu_addr), 0);
          check("rstm_dout", 32'(bus.mpu_data_out), 0);
          check("rstm_miso", 32'(miso), 0);
          @(negedge clk);
          reset = 1'b0;
        end
      end
    join
    check("rst_mid_done", exp_q.size(), 0);

    // Recovery after reset
    tx_bytes = '{8'h80, 8'h06, 8'h00, 8'h5A, 8'h5A};
    push_exp(1'b1, 16'h0600, 16'h5A5A, 2'b00, 4, 2);
    run_frame(40, 1'b0);
    check("recover_done", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_mpu_bridge.md
# spi_mpu_bridge

SPI-slave-to-MPU-bus initiator that lets an external SPI host drive the ChronoCube MPU-side bus (`_mpu_en`, `_mpu_rd`, `_mpu_wr`, `_mpu_be`, address, data) instead of a parallel microcontroller. It sits between the board SPI pins and the ChronoCube core and converts framed SPI transactions into timed, active-low bus read and write cycles. It supports burst access with address auto-increment. All logic runs on the system clock, and the SPI pins are oversampled.

## Interface
- `ADDR_WIDTH`, 16: MPU address width.
- `DATA_WIDTH`, 16: MPU data width; fixed at 2 SPI bytes per word.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `_spi_ss`  in  1  SPI slave select, active low; asynchronous to `clk`.
- `spi_sclk`  in  1  SPI clock, mode 0; asynchronous to `clk`.
- `spi_mosi`  in  1  SPI data from the host.
- `spi_miso`  out  1  SPI data to the host.
- `_mpu_en`  out  1  bus enable, active low.
- `_mpu_rd`  out  1  read strobe, active low.
- `_mpu_wr`  out  1  write strobe, active low.
- `_mpu_be`  out  2  byte enables, active low.
- `mpu_addr`  out  ADDR_WIDTH  bus address.
- `mpu_data_out`  out  DATA_WIDTH  write data to the core.
- `mpu_data_in`  in  DATA_WIDTH  read data from the core.
- `busy`  out  1  high while a bus cycle is in progress.

## Operation
- **Input synchronization**
  - `_spi_ss`, `spi_sclk` and `spi_mosi` each pass through a 2-flop synchronizer.
  - Rising and falling edges of `spi_sclk` are detected on the synchronized copies.
- **Bit handling**
  - MOSI is sampled on each synchronized sclk rising edge, MSB first.
  - MISO shifts on each falling edge.
  - While `_spi_ss` is high, the bit and byte counters clear.
- **Frame format**
  - Byte 0 is the command. cmd[7] = 1 for write, 0 for read. cmd[1:0] are latched and drive `_mpu_be` for every cycle in the frame. cmd[6:2] are ignored.
  - Bytes 1 and 2 are the address, high byte first.
- **Write frame**
  - Each following byte pair (high byte first) forms one word.
  - On the 16th bit of a word, a write cycle is issued at the current address, then the address increments.
- **Read frame**
  - Byte 3 is a dummy byte; the host ignores its MISO content.
  - When byte 2 completes, the first read cycle is issued.
  - On the falling edge that ends byte 3, and every 16 bits after that, the read word is loaded into the MISO shift register. At the same time the address increments and the next read is issued (prefetch).
- **Address**
  - Increments modulo 2^ADDR_WIDTH, so 0xFFFF wraps to 0x0000.
- **Bus-cycle FSM** (states IDLE, SETUP, STROBE1, STROBE2, HOLD)
  - IDLE: `_mpu_en`, `_mpu_rd` and `_mpu_wr` are high. A cycle request moves to SETUP.
  - SETUP: `_mpu_en` = 0; `mpu_addr`, `mpu_data_out` and `_mpu_be` are valid. For reads, `_mpu_rd` = 0 here.
  - STROBE1 and STROBE2: `_mpu_wr` = 0 for writes, or `_mpu_rd` = 0 for reads.
  - At the end of STROBE2, reads capture `mpu_data_in` into the read buffer.
  - HOLD: strobes high, `_mpu_en` = 0, address and data held; then return to IDLE.
  - `busy` = 1 in every state except IDLE.
- **Abort**
  - `_spi_ss` rising mid-frame discards any partial word and issues no new cycle.
  - An in-flight bus cycle runs to completion and is never truncated.
- **Reset values**
  - `_mpu_en`, `_mpu_rd`, `_mpu_wr` = 1.
  - `_mpu_be` = 2'b11.
  - `mpu_addr`, `mpu_data_out` = 0.
  - `spi_miso` = 0, `busy` = 0.
  - FSM in IDLE; counters and the command register cleared.
- **Reset mid-cycle**
  - All strobes deassert on the next `clk` edge.
  - The SPI frame is lost; the host must restart with `_spi_ss` high.

## Timing
- Synchronizer plus edge detect adds 3 `clk` of latency from an SPI pin to internal action.
- The host must hold `spi_sclk` high ≥ 4 `clk` and low ≥ 4 `clk`.
- `_spi_ss` must fall ≥ 4 `clk` before the first sclk rising edge.
- A bus cycle is 5 `clk`, IDLE back to IDLE.
- Under the SPI timing above, a word spans ≥ 128 `clk`, so cycles never overlap. No overrun queue exists.
- The write cycle enters SETUP 1 `clk` after the 16th detected rising edge of the word.
- The read word is valid on MISO within 1 `clk` of the loading falling edge, which is ≥ 4 `clk` before the next rising edge.
- Simultaneous `_spi_ss` rise and word completion: the word counts as complete and its cycle is issued.

## Test plan
- **Single write:** cmd 0x80, addr 0x0123, data 0xBEEF → one cycle with `mpu_addr` = 0x0123, `mpu_data_out` = 0xBEEF, `_mpu_be` = 00; `_mpu_wr` low for exactly 2 `clk`; `_mpu_en` low for 4 `clk`.
- **Burst write with wrap:** cmd 0x80, addr 0xFFFF, words 0x1111 and 0x2222 → writes to 0xFFFF and then 0x0000.
- **Burst read:** cmd 0x00, addr 0x0040, dummy byte, 2 words, with a model returning addr^0xA5A5 → MISO returns 0xA5E5 then 0xA5E4; 3 read cycles observed (2 plus 1 prefetch).
- **Byte enables:** cmd 0x82, addr 0x0010, data 0x00FF → `_mpu_be` = 2'b10 during the cycle and 2'b11 in IDLE.
- **Abort:** `_spi_ss` raised after 9 bits of a write word → no write cycle; a following frame starts cleanly.
- **Reset mid-cycle:** assert `reset` in STROBE1 of a write → `_mpu_wr`, `_mpu_en` = 1 and `busy` = 0 on the next edge; outputs match the reset values.
